// File: rtl/decode_stage_pkg.sv
// Shared execute package for the RV32I decode stage.
// Holds the ALU function encoding consumed by execute, the immediate format
// selector used by imm_gen, and the RV32I opcode/funct3/funct7 constants.
// Helper functions classify funct3 values that are legal for
// LOAD/STORE/BRANCH.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_DISABLE       = 4'd0,
    ALU_ADD           = 4'd1,
    ALU_SUB           = 4'd2,
    ALU_AND           = 4'd3,
    ALU_OR            = 4'd4,
    ALU_XOR           = 4'd5,
    ALU_SLL           = 4'd6,
    ALU_SRL           = 4'd7,
    ALU_SRA           = 4'd8,
    ALU_ADD_SIGN_FLIP = 4'd9
  } e_alu_function;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } e_imm_fmt;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // LB, LH, LW, LBU, LHU
  function automatic logic is_load_f3(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // SB, SH, SW
  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
  endfunction

  // BEQ, BNE, BLT, BGE, BLTU, BGEU
  function automatic logic is_branch_f3(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake/bus interface of the decode stage.
// Fetch side : in_valid, in_ready, in_pc, in_instr.
// ALU side   : out_valid, out_ready, out_alu_function, out_op1, out_op2,
//              out_rd, out_rd_we, out_pc and, with DECODE_ILLEGAL_EN
//              defined, out_illegal.
// Modports   : slave = decode stage, master = surrounding pipeline.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  e_alu_function out_alu_function;
  logic [31:0]   out_op1;
  logic [31:0]   out_op2;
  logic [4:0]    out_rd;
  logic          out_rd_we;
  logic [31:0]   out_pc;
`ifdef DECODE_ILLEGAL_EN
  logic          out_illegal;
`endif

  modport slave (
`ifdef DECODE_ILLEGAL_EN
    output out_illegal,
`endif
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_alu_function, out_op1, out_op2,
           out_rd, out_rd_we, out_pc
  );

  modport master (
`ifdef DECODE_ILLEGAL_EN
    input  out_illegal,
`endif
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_alu_function, out_op1, out_op2,
           out_rd, out_rd_we, out_pc
  );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: purely combinational RV32I immediate generator.
// Ports: instr (instruction bits [31:7]; the opcode is not needed),
//        fmt (I/S/B/U/J format select), imm (sign-extended immediate).
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:7] instr,
  input  e_imm_fmt    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with a single-entry output register.
// Ports: clk, rst (async active-high); bus (decode_stage_if.slave) carrying
//        the fetch-side and ALU-side handshakes and payloads; rs1_addr /
//        rs2_addr (combinational register-file read addresses); rs1_data /
//        rs2_data (same-cycle read data); flush (kill held and incoming word).
// Optional: define DECODE_ILLEGAL_EN to add bus.out_illegal, flagging
//           unsupported encodings. Without it they are silent ALU_DISABLE
//           slots that still carry valid=1.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  bus,
  output logic [4:0]     rs1_addr,
  output logic [4:0]     rs2_addr,
  input  logic [31:0]    rs1_data,
  input  logic [31:0]    rs2_data,
  input  logic           flush
);

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rd;
  logic          f7_base;
  logic          f7_alt;
  logic [31:0]   imm;
  e_imm_fmt      fmt_p0;
  e_alu_function fn_p0;
  logic [31:0]   op1_p0;
  logic [31:0]   op2_p0;
  logic          wb_p0;
  logic          rd_we_p0;

  assign opcode   = bus.in_instr[6:0];
  assign rd       = bus.in_instr[11:7];
  assign funct3   = bus.in_instr[14:12];
  assign funct7   = bus.in_instr[31:25];
  assign rs1_addr = bus.in_instr[19:15];
  assign rs2_addr = bus.in_instr[24:20];
  assign f7_base  = (funct7 == F7_BASE);
  assign f7_alt   = (funct7 == F7_ALT);

  assign fmt_p0 = (opcode == OPC_STORE) ? IMM_S :
                  ((opcode == OPC_LUI) || (opcode == OPC_AUIPC)) ? IMM_U : IMM_I;

  imm_gen u_imm_gen (
    .instr (bus.in_instr[31:7]),
    .fmt   (fmt_p0),
    .imm   (imm)
  );

  // Stage p0: combinational decode of the incoming word
  always_comb begin
    fn_p0  = ALU_DISABLE;
    op1_p0 = '0;
    op2_p0 = '0;
    wb_p0  = 1'b0;
    case (opcode)
      OPC_OP: begin
        op1_p0 = rs1_data;
        op2_p0 = rs2_data;
        wb_p0  = 1'b1;
        case (funct3)
          F3_ADD_SUB: fn_p0 = f7_base ? ALU_ADD : (f7_alt ? ALU_SUB : ALU_DISABLE);
          F3_SLL:     if (f7_base) fn_p0 = ALU_SLL;
          F3_XOR:     if (f7_base) fn_p0 = ALU_XOR;
          F3_OR:      if (f7_base) fn_p0 = ALU_OR;
          F3_AND:     if (f7_base) fn_p0 = ALU_AND;
          F3_SRL_SRA: fn_p0 = f7_base ? ALU_SRL : (f7_alt ? ALU_SRA : ALU_DISABLE);
          default:    fn_p0 = ALU_DISABLE;  // SLT / SLTU
        endcase
      end
      OPC_OP_IMM: begin
        op1_p0 = rs1_data;
        op2_p0 = imm;
        wb_p0  = 1'b1;
        case (funct3)
          F3_ADD_SUB: fn_p0 = ALU_ADD;
          F3_XOR:     fn_p0 = ALU_XOR;
          F3_OR:      fn_p0 = ALU_OR;
          F3_AND:     fn_p0 = ALU_AND;
          F3_SLL: begin
            op2_p0 = {27'b0, bus.in_instr[24:20]};
            if (f7_base) fn_p0 = ALU_SLL;
          end
          F3_SRL_SRA: begin
            op2_p0 = {27'b0, bus.in_instr[24:20]};
            fn_p0  = f7_base ? ALU_SRL : (f7_alt ? ALU_SRA : ALU_DISABLE);
          end
          default:    fn_p0 = ALU_DISABLE;  // SLTI / SLTIU
        endcase
      end
      OPC_LUI: begin
        fn_p0  = ALU_ADD;
        op2_p0 = imm;
        wb_p0  = 1'b1;
      end
      OPC_AUIPC: begin
        fn_p0  = ALU_ADD;
        op1_p0 = bus.in_pc;
        op2_p0 = imm;
        wb_p0  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU produces the link address pc+4; JALR needs funct3=000.
        if ((opcode == OPC_JAL) || (funct3 == 3'b000)) fn_p0 = ALU_ADD;
        op1_p0 = bus.in_pc;
        op2_p0 = 32'd4;
        wb_p0  = 1'b1;
      end
      OPC_LOAD: begin
        if (is_load_f3(funct3)) fn_p0 = ALU_ADD;
        op1_p0 = rs1_data;
        op2_p0 = imm;
        wb_p0  = 1'b1;
      end
      OPC_STORE: begin
        if (is_store_f3(funct3)) fn_p0 = ALU_ADD;
        op1_p0 = rs1_data;
        op2_p0 = imm;
      end
      OPC_BRANCH: begin
        if (is_branch_f3(funct3)) fn_p0 = ALU_SUB;
        op1_p0 = rs1_data;
        op2_p0 = rs2_data;
      end
      default: fn_p0 = ALU_DISABLE;
    endcase
    // Unsupported encodings leave the ALU idle with zeroed operands.
    if (fn_p0 == ALU_DISABLE) begin
      op1_p0 = '0;
      op2_p0 = '0;
      wb_p0  = 1'b0;
    end
  end

  assign rd_we_p0 = wb_p0 && (rd != 5'd0);

  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  // Stage p0 -> p1: output register; flush beats a same-cycle accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid        <= 1'b0;
      bus.out_rd_we        <= 1'b0;
      bus.out_alu_function <= ALU_DISABLE;
      bus.out_op1          <= '0;
      bus.out_op2          <= '0;
      bus.out_pc           <= '0;
      bus.out_rd           <= '0;
`ifdef DECODE_ILLEGAL_EN
      bus.out_illegal      <= 1'b0;
`endif
    end else if (flush) begin
      bus.out_valid        <= 1'b0;
      bus.out_rd_we        <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
      bus.out_illegal      <= 1'b0;
`endif
    end else if (bus.in_ready) begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out_rd_we        <= rd_we_p0;
        bus.out_alu_function <= fn_p0;
        bus.out_op1          <= op1_p0;
        bus.out_op2          <= op2_p0;
        bus.out_pc           <= bus.in_pc;
        bus.out_rd           <= rd;
`ifdef DECODE_ILLEGAL_EN
        bus.out_illegal      <= (fn_p0 == ALU_DISABLE);
`endif
      end else begin
        bus.out_rd_we        <= 1'b0;
`ifdef DECODE_ILLEGAL_EN
        bus.out_illegal      <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset. Ports: clk in 1 (clock); rst in 1 (async active-high reset).
REQ-002 SHALL have port: in_valid  in  1  fetch-side instruction valid.
REQ-003 SHALL have port: in_ready  out  1  stage can accept.
REQ-004 SHALL have port: in_pc  in  32  instruction address.
REQ-005 SHALL have port: in_instr  in  32  RV32I instruction word.
REQ-006 SHALL have ports: rs1_addr, rs2_addr  out  5 each  register-file read addresses, combinational from in_instr.
REQ-007 SHALL have ports: rs1_data, rs2_data  in  32 each  register-file read data, same cycle.
REQ-008 SHALL have port: flush  in  1  kill the held and incoming instruction.
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1 (ALU-side handshake).
REQ-010 SHALL have ports: out_alu_function out e_alu_function; out_op1 out 32; out_op2 out 32.
REQ-011 SHALL have ports: out_rd out 5; out_rd_we out 1; out_pc out 32.

Function
REQ-012 SHALL register one instruction: latency 1 cycle from an accepted in_valid&&in_ready to out_valid.
REQ-013 SHALL drive in_ready = !out_valid || out_ready (single-entry pipeline register, full throughput).
REQ-014 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-015 SHALL clear out_valid on the cycle after flush=1; flush takes priority over a simultaneous accept, and the accepted word is dropped.
REQ-016 SHALL decode OP (R-type): op1=rs1_data, op2=rs2_data; ADD/SUB/AND/OR/XOR/SLL/SRL/SRA map to ALU_ADD/ALU_SUB/ALU_AND/ALU_OR/ALU_XOR/ALU_SLL/ALU_SRL/ALU_SRA; funct7[5] selects SUB and SRA.
REQ-017 SHALL decode OP-IMM: op1=rs1_data, op2=sign-extended imm[11:0]; SLLI/SRLI/SRAI use op2={27'b0,shamt}.
REQ-018 SHALL decode LUI as ALU_ADD, op1=0, op2={imm[31:12],12'b0}; AUIPC the same with op1=in_pc.
REQ-019 SHALL decode JAL/JALR as ALU_ADD, op1=in_pc, op2=4, producing the link value.
REQ-020 SHALL decode LOAD/STORE as ALU_ADD, op1=rs1_data, op2=I- or S-immediate sign-extended; BRANCH as ALU_SUB, op1=rs1_data, op2=rs2_data.
REQ-021 SHALL set out_rd_we=1 only for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, and only when rd!=0.
REQ-022 SHALL never emit ALU_ADD_SIGN_FLIP; SLT/SLTI/SLTU/SLTIU and all other encodings SHALL be treated as unsupported: ALU_DISABLE, out_rd_we=0.
REQ-023 SHALL treat a flushed or invalid slot as a bubble: out_valid=0 and out_rd_we=0.

Reset
REQ-024 SHALL, on rst=1, asynchronously force out_valid=0, out_rd_we=0, out_alu_function=ALU_DISABLE, and out_op1, out_op2, out_pc and out_rd to 0.
REQ-025 SHALL discard any in-flight instruction when reset is asserted mid-operation; in_ready=1 on the first cycle after release.

Configuration
REQ-026 SHALL use macro DECODE_ILLEGAL_EN. When defined: add port out_illegal (out, 1), registered with the outputs, set for every unsupported encoding under REQ-022 and 0 after reset. When undefined: the port is absent and unsupported encodings are silent ALU_DISABLE bubbles with valid=1.

Structure
REQ-027 SHALL take e_alu_function from the shared execute package; RV32I opcode, funct3 and funct7 constants SHALL be added to that package.
REQ-028 SHALL put the immediate generator (I/S/B/U/J formats) in sub-module imm_gen (purely combinational); the decode table and the pipeline register stay in decode_stage.

Verification
REQ-029 SHALL cover: 0x00500093 (ADDI x1,x0,5), rs1_data=0 -> next cycle ALU_ADD, op1=0, op2=5, rd=1, rd_we=1.
REQ-030 SHALL cover: 0x402081B3 (SUB x3,x1,x2), rs1_data=9, rs2_data=4 -> ALU_SUB, op1=9, op2=4, rd=3.
REQ-031 SHALL cover: 0x40335293 (SRAI x5,x6,3) -> ALU_SRA, op2=3; and 0x123453B7 (LUI x7) -> ALU_ADD, op1=0, op2=0x12345000.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged; out_ready=1 -> the next word appears one cycle later.
REQ-033 SHALL cover: flush=1 coincident with an accept -> out_valid=0 next cycle; rst pulsed mid-stall -> all outputs take their REQ-024 values immediately.
REQ-034 SHALL cover: 0xFFFFFFFF -> ALU_DISABLE, rd_we=0; with DECODE_ILLEGAL_EN defined, out_illegal=1.
